// File: rtl/alu_issue_ctrl_if.sv
// Decode/ALU-side handshake bundle for the issue controller.
// The slave modport is the controller; the master modport is the decode/execute side.
interface alu_issue_ctrl_if;
   logic       iDecValid;
   logic       oDecReady;
   logic [6:0] iOpcode;
   logic [4:0] iRs1Addr;
   logic [4:0] iRs2Addr;
   logic [4:0] iRdAddr;
   logic       oAluIssue;
   logic       iWbValid;
   logic [4:0] iWbAddr;
   logic       iBrResolved;
   logic       iBrTaken;
   logic       oFlush;
   logic [2:0] oLoadsOut;
   logic       oBrTimeoutErr;

   modport master (
      output iDecValid, iOpcode, iRs1Addr, iRs2Addr, iRdAddr,
      output iWbValid, iWbAddr, iBrResolved, iBrTaken,
      input  oDecReady, oAluIssue, oFlush, oLoadsOut, oBrTimeoutErr
   );

   modport slave (
      input  iDecValid, iOpcode, iRs1Addr, iRs2Addr, iRdAddr,
      input  iWbValid, iWbAddr, iBrResolved, iBrTaken,
      output oDecReady, oAluIssue, oFlush, oLoadsOut, oBrTimeoutErr
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/hazard controller between decode and the ALU: load scoreboard, load limit,
// branch wait with timeout, and a one-cycle flush after taken branches or jumps.
module alu_issue_ctrl #(
   parameter int cRegCount  = 32,
   parameter int cMaxLoads  = 4,
   parameter int cBrTimeout = 15
) (
   input logic             iClk,
   input logic             iRst,
   alu_issue_ctrl_if.slave bus
);
   localparam int cCntW = $clog2(cMaxLoads + 1);
   localparam int cTmoW = $clog2(cBrTimeout + 1);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef enum logic [1:0] {RUN, BR_WAIT, FLUSH} state_e;

   state_e               state_q, state_d;
   logic [cRegCount-1:0] sb_q, sb_d, sb_eff;
   logic [cCntW-1:0]     cnt_q, cnt_d;
   logic [cTmoW-1:0]     tmo_q, tmo_d;
   logic                 jump_q, jump_d;
   logic                 flush_q, flush_d;
   logic                 err_q, err_d;

   logic uses_rs1, uses_rs2, is_load, is_ctrl, is_jump;
   logic wb_eff, hazard, load_full, ready, issue, issue_load;

   always_comb begin
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      is_load  = 1'b0;
      is_ctrl  = 1'b0;
      is_jump  = 1'b0;
      case (bus.iOpcode)
         OPC_OP, OPC_STORE: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         OPC_BRANCH: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            is_ctrl  = 1'b1;
         end
         OPC_LOAD: begin
            uses_rs1 = 1'b1;
            is_load  = 1'b1;
         end
         OPC_OPIMM: uses_rs1 = 1'b1;
         OPC_JALR: begin
            uses_rs1 = 1'b1;
            is_ctrl  = 1'b1;
            is_jump  = 1'b1;
         end
         OPC_JAL: begin
            is_ctrl = 1'b1;
            is_jump = 1'b1;
         end
         OPC_LUI, OPC_AUIPC: ;
         default: ;
      endcase
   end

   // A completing load clears its bit before the hazard check (bypass-clear);
   // a writeback with no loads outstanding is ignored entirely.
   assign wb_eff = bus.iWbValid && (cnt_q != '0);

   always_comb begin
      sb_eff = sb_q;
      if (wb_eff) sb_eff[bus.iWbAddr] = 1'b0;
   end

   assign hazard     = (uses_rs1 && sb_eff[bus.iRs1Addr]) ||
                       (uses_rs2 && sb_eff[bus.iRs2Addr]) ||
                       (is_load  && sb_eff[bus.iRdAddr]);
   assign load_full  = (cnt_q == cCntW'(cMaxLoads)) && !wb_eff;
   assign ready      = iRst && (state_q == RUN) && !hazard && !(is_load && load_full);
   assign issue      = bus.iDecValid && ready;
   assign issue_load = issue && is_load;

   always_comb begin
      sb_d    = sb_eff;
      cnt_d   = cnt_q;
      state_d = state_q;
      tmo_d   = tmo_q;
      jump_d  = jump_q;
      err_d   = err_q;

      // Setting after the writeback clear lets a new load to the same rd win.
      if (issue_load && (bus.iRdAddr != '0)) sb_d[bus.iRdAddr] = 1'b1;
      sb_d[0] = 1'b0;

      if (issue_load && !wb_eff)      cnt_d = cnt_q + cCntW'(1);
      else if (!issue_load && wb_eff) cnt_d = cnt_q - cCntW'(1);

      case (state_q)
         RUN: begin
            if (issue && is_ctrl) begin
               state_d = BR_WAIT;
               tmo_d   = '0;
               jump_d  = is_jump;
            end
         end
         BR_WAIT: begin
            tmo_d = tmo_q + cTmoW'(1);
            if (bus.iBrResolved) begin
               if (bus.iBrTaken || jump_q) state_d = FLUSH;
               else                        state_d = RUN;
            end else if (tmo_d == cTmoW'(cBrTimeout)) begin
               err_d   = 1'b1;
               state_d = RUN;
            end
         end
         FLUSH:   state_d = RUN;
         default: state_d = RUN;
      endcase

      flush_d = (state_d == FLUSH);
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state_q <= RUN;
         sb_q    <= '0;
         cnt_q   <= '0;
         tmo_q   <= '0;
         jump_q  <= 1'b0;
         flush_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sb_q    <= sb_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         jump_q  <= jump_d;
         flush_q <= flush_d;
         err_q   <= err_d;
      end
   end

   assign bus.oDecReady     = ready;
   assign bus.oAluIssue     = issue;
   assign bus.oFlush        = flush_q;
   assign bus.oLoadsOut     = 3'(cnt_q);
   assign bus.oBrTimeoutErr = err_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed scoreboard bench for alu_issue_ctrl: each driven cycle pushes its
// hand-computed expected outputs, and a monitor pops and compares on the falling edge.
module tb_alu_issue_ctrl;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef struct {
      string name;
      int    ready;
      int    issue;
      int    flush;
      int    loads;
      int    err;
   } exp_t;

   logic iClk = 1'b0;
   logic iRst = 1'b0;
   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   alu_issue_ctrl_if bus ();

   alu_issue_ctrl dut (
      .iClk (iClk),
      .iRst (iRst),
      .bus  (bus)
   );

   always #5 iClk = ~iClk;

   // Compares the live outputs against one expected set and tallies the result.
   task automatic checkOutput(input string name, input int e_ready, input int e_issue,
                              input int e_flush, input int e_loads, input int e_err);
      checks++;
      if (bus.oDecReady !== 1'(e_ready) || bus.oAluIssue !== 1'(e_issue) ||
          bus.oFlush !== 1'(e_flush) || bus.oLoadsOut !== 3'(e_loads) ||
          bus.oBrTimeoutErr !== 1'(e_err)) begin
         errors++;
         $display("[TB] FAIL %s: got rdy=%0b iss=%0b flush=%0b loads=%0d err=%0b, want rdy=%0d iss=%0d flush=%0d loads=%0d err=%0d",
                  name, bus.oDecReady, bus.oAluIssue, bus.oFlush, bus.oLoadsOut,
                  bus.oBrTimeoutErr, e_ready, e_issue, e_flush, e_loads, e_err);
      end
   endtask

   // Drives one cycle of inputs just after the rising edge and queues what that cycle should show.
   task automatic applyStimulus(input string name, input int v, input logic [6:0] op,
                                input int rs1, input int rs2, input int rd,
                                input int wb, input int wba, input int br, input int bt,
                                input int e_ready, input int e_issue, input int e_flush,
                                input int e_loads, input int e_err);
      exp_t e;
      @(posedge iClk);
      #1;
      bus.iDecValid   = (v != 0);
      bus.iOpcode     = op;
      bus.iRs1Addr    = 5'(rs1);
      bus.iRs2Addr    = 5'(rs2);
      bus.iRdAddr     = 5'(rd);
      bus.iWbValid    = (wb != 0);
      bus.iWbAddr     = 5'(wba);
      bus.iBrResolved = (br != 0);
      bus.iBrTaken    = (bt != 0);
      e.name  = name;
      e.ready = e_ready;
      e.issue = e_issue;
      e.flush = e_flush;
      e.loads = e_loads;
      e.err   = e_err;
      exp_q.push_back(e);
   endtask

   // Monitor: consumes one queued expectation per falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge iClk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput(e.name, e.ready, e.issue, e.flush, e.loads, e.err);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.iDecValid   = 1'b1;
      bus.iOpcode     = OPC_OP;
      bus.iRs1Addr    = 5'd1;
      bus.iRs2Addr    = 5'd2;
      bus.iRdAddr     = 5'd3;
      bus.iWbValid    = 1'b0;
      bus.iWbAddr     = 5'd0;
      bus.iBrResolved = 1'b0;
      bus.iBrTaken    = 1'b0;
      #2;
      checkOutput("reset_state", 0, 0, 0, 0, 0);
      bus.iDecValid = 1'b0;
      @(posedge iClk);
      #1;
      iRst = 1'b1;

      // Back-to-back R-type adds with no loads.
      for (int i = 0; i < 8; i++)
         applyStimulus($sformatf("add_b2b_%0d", i), 1, OPC_OP, 1, 2, 3, 0, 0, 0, 0, 1, 1, 0, 0, 0);

      // RAW on a load destination, released by a same-cycle writeback.
      applyStimulus("ld_x5",        1, OPC_LOAD, 1, 0, 5, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      applyStimulus("raw_stall_1",  1, OPC_OP,   5, 1, 6, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      applyStimulus("raw_stall_2",  1, OPC_OP,   5, 1, 6, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      applyStimulus("raw_bypass",   1, OPC_OP,   5, 1, 6, 1, 5, 0, 0, 1, 1, 0, 1, 0);
      applyStimulus("x5_cleared",   1, OPC_OP,   1, 5, 7, 0, 0, 0, 0, 1, 1, 0, 0, 0);

      // Load-outstanding limit, relieved by a writeback in the stall cycle.
      applyStimulus("ld_x1",        1, OPC_LOAD, 10, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      applyStimulus("ld_x2",        1, OPC_LOAD, 10, 0, 2, 0, 0, 0, 0, 1, 1, 0, 1, 0);
      applyStimulus("ld_x3",        1, OPC_LOAD, 10, 0, 3, 0, 0, 0, 0, 1, 1, 0, 2, 0);
      applyStimulus("ld_x4",        1, OPC_LOAD, 10, 0, 4, 0, 0, 0, 0, 1, 1, 0, 3, 0);
      applyStimulus("ld_full",      1, OPC_LOAD, 10, 0, 7, 0, 0, 0, 0, 0, 0, 0, 4, 0);
      applyStimulus("ld_full_wb",   1, OPC_LOAD, 10, 0, 7, 1, 2, 0, 0, 1, 1, 0, 4, 0);
      applyStimulus("drain_x1",     0, OPC_OP,   0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 4, 0);
      applyStimulus("drain_x3",     0, OPC_OP,   0, 0, 0, 1, 3, 0, 0, 1, 0, 0, 3, 0);
      applyStimulus("drain_x4",     0, OPC_OP,   0, 0, 0, 1, 4, 0, 0, 1, 0, 0, 2, 0);
      applyStimulus("drain_x7",     0, OPC_OP,   0, 0, 0, 1, 7, 0, 0, 1, 0, 0, 1, 0);
      applyStimulus("drained",      0, OPC_OP,   0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

      // Taken branch: one wait cycle, one flush cycle, issue three cycles later.
      applyStimulus("beq_t",        1, OPC_BRANCH, 1, 2, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      applyStimulus("beq_t_wait",   1, OPC_OP,     1, 2, 3, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      applyStimulus("beq_t_flush",  1, OPC_OP,     1, 2, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      applyStimulus("beq_t_next",   1, OPC_OP,     1, 2, 3, 0, 0, 0, 0, 1, 1, 0, 0, 0);

      // Not-taken branch: issue two cycles later, no flush.
      applyStimulus("beq_nt",       1, OPC_BRANCH, 1, 2, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      applyStimulus("beq_nt_wait",  1, OPC_OP,     1, 2, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      applyStimulus("beq_nt_next",  1, OPC_OP,     1, 2, 3, 0, 0, 0, 0, 1, 1, 0, 0, 0);

      // A jump flushes even when reported not taken.
      applyStimulus("jal",          1, OPC_JAL, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      applyStimulus("jal_wait",     1, OPC_OP,  1, 2, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      applyStimulus("jal_flush",    1, OPC_OP,  1, 2, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      applyStimulus("jal_next",     1, OPC_OP,  1, 2, 3, 0, 0, 0, 0, 1, 1, 0, 0, 0);

      // Branch timeout: fifteen wait cycles, then sticky error and back to RUN.
      applyStimulus("bne_tmo",      1, OPC_BRANCH, 1, 2, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      for (int i = 1; i <= 15; i++)
         applyStimulus($sformatf("tmo_wait_%0d", i), 1, OPC_OP, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus("tmo_run",      1, OPC_OP, 1, 2, 3, 0, 0, 0, 0, 1, 1, 0, 0, 1);
      applyStimulus("tmo_late_res", 0, OPC_OP, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1);
      applyStimulus("tmo_no_flush", 0, OPC_OP, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);

      // x0 loads count but never block; writeback with nothing outstanding is ignored.
      applyStimulus("ld_x0_a",      1, OPC_LOAD, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
      applyStimulus("ld_x0_b",      1, OPC_LOAD, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1);
      applyStimulus("add_x0",       1, OPC_OP,   0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 2, 1);
      applyStimulus("wb_x0_a",      0, OPC_OP,   0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 2, 1);
      applyStimulus("wb_x0_b",      0, OPC_OP,   0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1);
      applyStimulus("wb_empty",     0, OPC_OP,   0, 0, 0, 1, 3, 0, 0, 1, 0, 0, 0, 1);
      applyStimulus("no_underflow", 0, OPC_OP,   0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);

      // Reset asserted while waiting on a branch with a load outstanding.
      applyStimulus("ld_x9",        1, OPC_LOAD,   0, 0, 9, 0, 0, 0, 0, 1, 1, 0, 0, 1);
      applyStimulus("beq_rst",      1, OPC_BRANCH, 1, 2, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1);
      applyStimulus("beq_rst_wait", 1, OPC_OP,     1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      @(posedge iClk);
      #1;
      bus.iBrResolved = 1'b1;
      bus.iBrTaken    = 1'b1;
      #1;
      iRst = 1'b0;
      #1;
      checkOutput("rst_async", 0, 0, 0, 0, 0);
      @(posedge iClk);
      #1;
      checkOutput("rst_held", 0, 0, 0, 0, 0);
      bus.iBrResolved = 1'b0;
      bus.iBrTaken    = 1'b0;
      bus.iDecValid   = 1'b0;
      iRst = 1'b1;
      applyStimulus("post_rst_a",   0, OPC_OP, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      applyStimulus("post_rst_b",   1, OPC_OP, 9, 1, 2, 0, 0, 0, 0, 1, 1, 0, 0, 0);

      for (int i = 0; i < 20 && exp_q.size() > 0; i++)
         @(negedge iClk);
      #1;
      if (exp_q.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
